regfile_requester: RTL

//  Initiator side of the 32x8 register-file port: valid[2:0] = {write, read1, read2}, plus three addresses and write data.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_requester_if.sv | 23 ++
 rtl/regfile_requester.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, valid-bit indices and requester FSM encoding for the register-file port
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int VB_WR  = 2;
  localparam int VB_RD1 = 1;
  localparam int VB_RD2 = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
endpackage

// File: rtl/regfile_requester_if.sv
// regfile_requester_if: upstream command/response handshake between sequencer (master) and requester (slave)
interface regfile_requester_if;
  import regfile_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_en;
  logic [ADDR_W-1:0] cmd_raddr1;
  logic [ADDR_W-1:0] cmd_raddr2;
  logic [ADDR_W-1:0] cmd_waddr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  modport master (
    output cmd_valid, cmd_en, cmd_raddr1, cmd_raddr2, cmd_waddr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data1, rsp_data2
  );
  modport slave (
    input  cmd_valid, cmd_en, cmd_raddr1, cmd_raddr2, cmd_waddr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_requester.sv
// regfile_requester: issues one command per handshake to the register file and returns read data
module regfile_requester
  import regfile_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  regfile_requester_if.slave up,
  output logic [2:0]        rf_valid,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_1,
  input  logic [DATA_W-1:0] rf_read_2,
  output logic [CNT_W-1:0]  ops_issued
);
  state_e            state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data2_q;
  logic [2:0]        en_q;
  logic [2:0]        rf_valid_q;
  logic [ADDR_W-1:0] ra1_q;
  logic [ADDR_W-1:0] ra2_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [CNT_W-1:0]  ops_q;
  // rf_* are loaded at accept so they are already valid for the whole ISSUE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      en_q        <= '0;
      rf_valid_q  <= '0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      ops_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (up.cmd_valid && up.cmd_en != 3'b000) begin
          en_q        <= up.cmd_en;
          rf_valid_q  <= up.cmd_en;
          ra1_q       <= up.cmd_raddr1;
          ra2_q       <= up.cmd_raddr2;
          wa_q        <= up.cmd_waddr;
          wd_q        <= up.cmd_wdata;
          cmd_ready_q <= 1'b0;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          rf_valid_q <= '0;
          ops_q      <= (&ops_q) ? ops_q : ops_q + 1'b1;
          if (en_q[VB_RD1] || en_q[VB_RD2]) begin
            state_q <= CAPTURE;
          end else begin
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        CAPTURE: begin
          rsp_data1_q <= en_q[VB_RD1] ? rf_read_1 : '0;
          rsp_data2_q <= en_q[VB_RD2] ? rf_read_2 : '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (up.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign up.cmd_ready    = cmd_ready_q;
  assign up.rsp_valid    = rsp_valid_q;
  assign up.rsp_data1    = rsp_data1_q;
  assign up.rsp_data2    = rsp_data2_q;
  assign rf_valid        = rf_valid_q;
  assign rf_read_addr_1  = ra1_q;
  assign rf_read_addr_2  = ra2_q;
  assign rf_write_addr   = wa_q;
  assign rf_write_data   = wd_q;
  assign ops_issued      = ops_q;
endmodule
